// File: rtl/pc_sequencer.sv
// Fetch-PC sequencer: owns the PC and Z/N flag registers and resolves J/BRZ/BRN/JM
// redirects from EX. It drives flush/busy so the front end can kill wrong-path fetches.
module pc_sequencer #(
   parameter int unsigned       ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int unsigned       FLUSH_DEPTH = 2,
   parameter int unsigned       FLAG_FWD    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              ex_valid,
   input  logic [1:0]        ex_pcsel,
   input  logic              ex_zflag,
   input  logic              ex_nflag,
   input  logic [ADDR_W-1:0] ex_target,
   input  logic              flag_we,
   input  logic              alu_z,
   input  logic              alu_n,
   output logic              jm_req,
   output logic [ADDR_W-1:0] jm_addr,
   input  logic              jm_ack,
   input  logic [ADDR_W-1:0] jm_data,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus1,
   output logic              flush,
   output logic              busy
);

   typedef enum logic {
      RUN     = 1'b0,
      JM_WAIT = 1'b1
   } state_t;

   localparam logic [1:0] PCSEL_BR = 2'b01;
   localparam logic [1:0] PCSEL_JM = 2'b10;

   // The flush counter holds the remaining squash cycles after the redirect pulse.
   localparam logic [3:0] SQ_RELOAD = 4'(FLUSH_DEPTH - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                jm_req_q, jm_req_d;
   logic [ADDR_W-1:0]   jm_addr_q, jm_addr_d;
   logic [3:0]          sq_cnt_q, sq_cnt_d;
   logic                z_q, z_d;
   logic                n_q, n_d;

   logic                squash;
   logic                acc;
   logic                zt, nt;
   logic                taken;
   logic                redirect_now;

   assign squash = (sq_cnt_q != 4'd0);
   assign acc    = ex_valid & ~stall & ~squash & (state_q == RUN);

   // With forwarding on, a flag write in the same cycle overrides the registered flags.
   assign zt    = (FLAG_FWD != 0 && flag_we) ? alu_z : z_q;
   assign nt    = (FLAG_FWD != 0 && flag_we) ? alu_n : n_q;
   assign taken = (~ex_zflag & ~ex_nflag) | (ex_zflag & zt) | (ex_nflag & nt);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no branch of the case can infer a latch.
      state_d      = state_q;
      pc_d         = pc_q;
      jm_req_d     = jm_req_q;
      jm_addr_d    = jm_addr_q;
      sq_cnt_d     = squash ? (sq_cnt_q - 4'd1) : sq_cnt_q;
      z_d          = z_q;
      n_d          = n_q;
      redirect_now = 1'b0;

      // Flag writes inside the squash window come from wrong-path instructions.
      if (flag_we && !squash) begin
         z_d = alu_z;
         n_d = alu_n;
      end

      case (state_q)
         RUN: begin
            if (acc && (ex_pcsel == PCSEL_BR) && taken) begin
               pc_d         = ex_target;
               redirect_now = 1'b1;
               sq_cnt_d     = SQ_RELOAD;
            end else if (acc && (ex_pcsel == PCSEL_JM)) begin
               state_d      = JM_WAIT;
               jm_req_d     = 1'b1;
               jm_addr_d    = ex_target;
               redirect_now = 1'b1;
               sq_cnt_d     = SQ_RELOAD;
            end else if (!stall) begin
               pc_d = pc_q + ADDR_W'(1);
            end
         end
         JM_WAIT: begin
            if (jm_ack) begin
               pc_d     = jm_data;
               jm_req_d = 1'b0;
               state_d  = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of its peers.
      if (rst) begin
         state_q   <= RUN;
         pc_q      <= RESET_PC;
         jm_req_q  <= 1'b0;
         jm_addr_q <= '0;
         sq_cnt_q  <= 4'd0;
         z_q       <= 1'b0;
         n_q       <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         jm_req_q  <= jm_req_d;
         jm_addr_q <= jm_addr_d;
         sq_cnt_q  <= sq_cnt_d;
         z_q       <= z_d;
         n_q       <= n_d;
      end
   end

   assign pc       = pc_q;
   assign pc_plus1 = pc_q + ADDR_W'(1);
   assign jm_req   = jm_req_q;
   assign jm_addr  = jm_addr_q;
   assign busy     = (state_q == JM_WAIT);
   assign flush    = redirect_now | squash | ((state_q == JM_WAIT) & jm_ack);

endmodule
